// File: rtl/sync_fifo_param_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_if
// Bundles the handshake, data and status signals of sync_fifo_param so that
// producer/consumer logic and the FIFO agree on one set of names and widths.
//
// Parameters:
//   WIDTH  data word width in bits
//   DEPTH  number of FIFO entries (power of two, >= 4)
//
// Signals (direction seen from the FIFO, i.e. the slave modport):
//   clr                in   synchronous flush
//   fifo_wr_en         in   write request
//   fifo_wr_data       in   write data
//   fifo_rd_en         in   read request / pop
//   fifo_rd_data       out  read data
//   fifo_full          out  occupancy == DEPTH
//   fifo_almost_full   out  occupancy >= almost-full threshold
//   fifo_empty         out  occupancy == 0
//   fifo_almost_empty  out  occupancy <= almost-empty threshold
//   fifo_data_cnt      out  occupancy, 0..DEPTH
//   fifo_wr_err        out  write request rejected this cycle
//   fifo_rd_err        out  read request rejected this cycle
// -----------------------------------------------------------------------------
interface sync_fifo_param_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clr;
    logic              fifo_wr_en;
    logic [WIDTH-1:0]  fifo_wr_data;
    logic              fifo_rd_en;
    logic [WIDTH-1:0]  fifo_rd_data;
    logic              fifo_full;
    logic              fifo_almost_full;
    logic              fifo_empty;
    logic              fifo_almost_empty;
    logic [ADDR_W:0]   fifo_data_cnt;
    logic              fifo_wr_err;
    logic              fifo_rd_err;

    // Side that drives requests into the FIFO
    modport master (
        output clr,
        output fifo_wr_en,
        output fifo_wr_data,
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_full,
        input  fifo_almost_full,
        input  fifo_empty,
        input  fifo_almost_empty,
        input  fifo_data_cnt,
        input  fifo_wr_err,
        input  fifo_rd_err
    );

    // The FIFO itself
    modport slave (
        input  clr,
        input  fifo_wr_en,
        input  fifo_wr_data,
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_full,
        output fifo_almost_full,
        output fifo_empty,
        output fifo_almost_empty,
        output fifo_data_cnt,
        output fifo_wr_err,
        output fifo_rd_err
    );
endinterface

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO built on an internal register array, used to
// buffer words between datapath stages (array feed, result drain).
//
// Parameters:
//   WIDTH      data word width in bits
//   DEPTH      number of entries, power of two, >= 4
//   AF_THRESH  almost_full asserts when count >= AF_THRESH
//   AE_THRESH  almost_empty asserts when count <= AE_THRESH
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    sync_fifo_param_if.slave: clr, write/read requests, read data,
//          full/almost_full/empty/almost_empty flags, occupancy count and
//          per-cycle write/read rejection strobes
//
// Build option:
//   SYNC_FIFO_FWFT_EN  when defined, first-word-fall-through: the head word is
//                      driven combinationally and fifo_rd_en pops it. When
//                      undefined, reads are registered with 1-cycle latency.
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 512,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sync_fifo_param_if.slave     bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_CNT   = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0]   AE_CNT   = (ADDR_W+1)'(AE_THRESH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;

    logic flush;
    logic full;
    logic empty;
    logic rd_ok;
    logic wr_ok;

    // Reset and clr have the same effect, so a single flush term covers both;
    // requests arriving in a flush cycle are dropped silently.
    assign flush = ~rst_n | bus.clr;

    // Flags depend only on the registered count, never on the enables.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A pop in the same cycle frees a slot, so a full FIFO can still take
    // a write when a read is accepted alongside it.
    assign rd_ok = bus.fifo_rd_en & ~empty & ~flush;
    assign wr_ok = bus.fifo_wr_en & (~full | rd_ok) & ~flush;

    assign bus.fifo_wr_err       = bus.fifo_wr_en & ~wr_ok & ~flush;
    assign bus.fifo_rd_err       = bus.fifo_rd_en & ~rd_ok & ~flush;
    assign bus.fifo_full         = full;
    assign bus.fifo_empty        = empty;
    assign bus.fifo_almost_full  = (count >= AF_CNT);
    assign bus.fifo_almost_empty = (count <= AE_CNT);
    assign bus.fifo_data_cnt     = count;

    // Storage array; deliberately not reset so a flush leaves contents intact.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.fifo_wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    // Count moves only when exactly one side is accepted.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly; content is don't-care while empty.
    assign bus.fifo_rd_data = mem[rd_ptr];
`else
    logic [WIDTH-1:0] rd_data_q;

    // Registered read port: holds its value until the next accepted read.
    always_ff @(posedge clk) begin
        if (flush) begin
            rd_data_q <= '0;
        end else if (rd_ok) begin
            rd_data_q <= mem[rd_ptr];
        end
    end

    assign bus.fifo_rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Self-checking bench for sync_fifo_param (DEPTH=8, WIDTH=8, AF=6, AE=2).
// A queue-based reference model predicts accept/reject for each cycle and
// the resulting occupancy, flags and read data; the expected post-edge state
// is queued and a separate monitor compares it after each rising edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;
    localparam int WIDTH     = 8;
    localparam int DEPTH     = 8;
    localparam int AF_THRESH = 6;
    localparam int AE_THRESH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sync_fifo_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_THRESH(AF_THRESH),
        .AE_THRESH(AE_THRESH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int cnt;
        bit full;
        bit empty;
        bit af;
        bit ae;
        bit chk_data;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   model_q[$];
    int   last_rd = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t mon_e;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // One cycle of stimulus: drive, check combinational errors, advance model
    task automatic applyStimulus(input bit wr, input int data, input bit rd,
                                 input bit clr_i, input bit rstn_i);
        bit   flush;
        bit   rd_ok;
        bit   wr_ok;
        bit   exp_wr_err;
        bit   exp_rd_err;
        exp_t e;
        @(negedge clk);
        rst_n            = rstn_i;
        bus.clr          = clr_i;
        bus.fifo_wr_en   = wr;
        bus.fifo_wr_data = data[WIDTH-1:0];
        bus.fifo_rd_en   = rd;
        #1;
        flush = !rstn_i || clr_i;
        if (flush) begin
            exp_wr_err = 1'b0;
            exp_rd_err = 1'b0;
            model_q.delete();
            last_rd = 0;
        end else begin
            rd_ok = rd && (model_q.size() > 0);
            wr_ok = wr && ((model_q.size() < DEPTH) || rd_ok);
            exp_wr_err = wr && !wr_ok;
            exp_rd_err = rd && !rd_ok;
            if (rd_ok) last_rd = model_q.pop_front();
            if (wr_ok) model_q.push_back(data & ((1 << WIDTH) - 1));
        end
        checkOutput("wr_err", {31'b0, bus.fifo_wr_err}, {31'b0, exp_wr_err});
        checkOutput("rd_err", {31'b0, bus.fifo_rd_err}, {31'b0, exp_rd_err});
        e.cnt   = model_q.size();
        e.full  = (e.cnt == DEPTH);
        e.empty = (e.cnt == 0);
        e.af    = (e.cnt >= AF_THRESH);
        e.ae    = (e.cnt <= AE_THRESH);
`ifdef SYNC_FIFO_FWFT_EN
        e.chk_data = (e.cnt > 0);
        e.data     = (e.cnt > 0) ? model_q[0] : 0;
`else
        e.chk_data = 1'b1;
        e.data     = last_rd;
`endif
        exp_q.push_back(e);
    endtask

    // Monitor: after every rising edge compare the state the model predicted
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("data_cnt", 32'(bus.fifo_data_cnt), mon_e.cnt);
                checkOutput("full", {31'b0, bus.fifo_full}, {31'b0, mon_e.full});
                checkOutput("empty", {31'b0, bus.fifo_empty}, {31'b0, mon_e.empty});
                checkOutput("almost_full", {31'b0, bus.fifo_almost_full}, {31'b0, mon_e.af});
                checkOutput("almost_empty", {31'b0, bus.fifo_almost_empty}, {31'b0, mon_e.ae});
                if (mon_e.chk_data) begin
                    checkOutput("rd_data", 32'(bus.fifo_rd_data), mon_e.data);
                end
            end
        end
    end

    initial begin
        bit wr;
        bit rd;
        bit clr_r;
        bit rstn_r;
        bus.clr          = 1'b0;
        bus.fifo_wr_en   = 1'b0;
        bus.fifo_wr_data = '0;
        bus.fifo_rd_en   = 1'b0;

        // Reset
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Fill to full, then one rejected write
        for (int i = 0; i < 8; i++) applyStimulus(1, 'h11 + i, 0, 0, 1);
        applyStimulus(1, 'hEE, 0, 0, 1);

        // Simultaneous read/write while full, then drain plus one empty read
        applyStimulus(1, 'h99, 1, 0, 1);
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 0, 1);

        // Simultaneous read/write while empty
        applyStimulus(1, 'h5A, 1, 0, 1);
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);

        // Threshold walk: 7 in, 5 out, then drain
        for (int i = 0; i < 7; i++) applyStimulus(1, 'h30 + i, 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 1);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 0, 1);

        // Pointer wrap-around
        for (int i = 0; i < 6; i++) applyStimulus(1, 'h40 + i, 0, 0, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, 1);
        for (int i = 0; i < 6; i++) applyStimulus(1, 'hA0 + i, 0, 0, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, 1);

        // Flush via clr with a concurrent write, then via reset mid-burst
        for (int i = 0; i < 3; i++) applyStimulus(1, 'h70 + i, 0, 0, 1);
        applyStimulus(1, 'h77, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 'h60 + i, 0, 0, 1);
        applyStimulus(1, 'h66, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);

        // Single word into empty FIFO, observed with and without a read
        applyStimulus(1, 'h3C, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            wr     = ($urandom_range(0, 99) < 55);
            rd     = ($urandom_range(0, 99) < 50);
            clr_r  = ($urandom_range(0, 63) == 0);
            rstn_r = ($urandom_range(0, 127) != 0);
            applyStimulus(wr, int'($urandom_range(0, 255)), rd, clr_r, rstn_r);
        end
        applyStimulus(0, 0, 0, 0, 1);

        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
